// File: rtl/prim_byte_packer_pkg.sv
// rtl/prim_byte_packer_pkg.sv - shared types and sizing helpers for the byte packer
package prim_byte_packer_pkg;

  typedef enum logic [1:0] {
    FlushIdle,
    FlushActive,
    FlushDone
  } flush_st_e;

  // Width needed to hold a byte count in the range 0..nb inclusive.
  function automatic int bytes_to_cnt(input int nb);
    return $clog2(nb + 1);
  endfunction

endpackage

// File: rtl/prim_byte_compact.sv
// rtl/prim_byte_compact.sv - squeeze strobed bytes to the low end and count them
module prim_byte_compact
  import prim_byte_packer_pkg::*;
#(
  parameter int NB = 4,
  localparam int CW = bytes_to_cnt(NB)
) (
  input  logic [NB*8-1:0] data_i,
  input  logic [NB-1:0]   strb_i,
  output logic [NB*8-1:0] data_o,
  output logic [CW-1:0]   cnt_o
);

  int n;

  // Unused upper bytes stay zero so the packer can OR the result into storage.
  always_comb begin
    data_o = '0;
    n      = 0;
    for (int i = 0; i < NB; i++) begin
      if (strb_i[i]) begin
        data_o[n*8 +: 8] = data_i[i*8 +: 8];
        n = n + 1;
      end
    end
    cnt_o = CW'(n);
  end

endmodule

// File: rtl/prim_byte_packer.sv
// rtl/prim_byte_packer.sv - byte-granular width converter with strobe compaction and flush
module prim_byte_packer
  import prim_byte_packer_pkg::*;
#(
  parameter int InW  = 32,
  parameter int OutW = 64,
  localparam int InB    = InW / 8,
  localparam int OutB   = OutW / 8,
  localparam int DepthB = InB + OutB,
  localparam int CntW   = bytes_to_cnt(DepthB)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic [InW-1:0]  data_i,
  input  logic [InB-1:0]  strb_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [OutW-1:0] data_o,
  output logic [OutB-1:0] strb_o,
  input  logic            ready_i,
  input  logic            flush_i,
  output logic            flush_done_o,
  output logic [CntW-1:0] level_o
);

  localparam int OnesW = bytes_to_cnt(InB);

  logic [DepthB*8-1:0] store_q, store_d;
  logic [CntW-1:0]     cnt_q, cnt_d, pop, base;
  flush_st_e           state_q, state_d;
  logic [InB*8-1:0]    cdata;
  logic [OnesW-1:0]    ones;
  logic                ack_in, ack_out;

  prim_byte_compact #(.NB(InB)) u_compact (
    .data_i (data_i),
    .strb_i (strb_i),
    .data_o (cdata),
    .cnt_o  (ones)
  );

  // Handshake outputs depend on registered state only.
  assign ready_o      = (cnt_q <= CntW'(OutB)) && (state_q == FlushIdle);
  assign valid_o      = (cnt_q >= CntW'(OutB)) || ((state_q == FlushActive) && (cnt_q != '0));
  assign ack_in       = valid_i & ready_o;
  assign ack_out      = valid_o & ready_i;
  assign flush_done_o = (state_q == FlushDone);
  assign level_o      = cnt_q;

  always_comb begin
    strb_o = '0;
    data_o = '0;
    for (int k = 0; k < OutB; k++) begin
      strb_o[k] = CntW'(k) < cnt_q;
      if (strb_o[k]) data_o[k*8 +: 8] = store_q[k*8 +: 8];
    end
  end

  // Bytes above cnt are kept zero, so the shifted storage and the placed
  // compacted input can be merged with a plain OR.
  always_comb begin
    pop = '0;
    if (ack_out) pop = (cnt_q < CntW'(OutB)) ? cnt_q : CntW'(OutB);
    base    = cnt_q - pop;
    store_d = store_q >> {pop, 3'b000};
    cnt_d   = base;
    if (ack_in) begin
      store_d = store_d | ({{(OutB*8){1'b0}}, cdata} << {base, 3'b000});
      cnt_d   = base + CntW'(ones);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FlushIdle:   if (flush_i) state_d = FlushActive;
      FlushActive: if (cnt_d == '0) state_d = FlushDone;
      FlushDone:   state_d = FlushIdle;
      default:     state_d = FlushIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      store_q <= '0;
      cnt_q   <= '0;
      state_q <= FlushIdle;
    end else begin
      store_q <= store_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_prim_byte_packer.sv
// tb/tb_prim_byte_packer.sv - directed self-checking bench for prim_byte_packer
module tb_prim_byte_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // a: 32 -> 64
  logic a_valid, a_ready, a_valid_o, a_ready_i, a_flush, a_done;
  logic [31:0] a_data; logic [3:0] a_strb;
  logic [63:0] a_data_o; logic [7:0] a_strb_o; logic [3:0] a_level;
  // b: 32 -> 32
  logic b_valid, b_ready, b_valid_o, b_ready_i, b_flush, b_done;
  logic [31:0] b_data; logic [3:0] b_strb;
  logic [31:0] b_data_o; logic [3:0] b_strb_o; logic [3:0] b_level;
  // c: 64 -> 32
  logic c_valid, c_ready, c_valid_o, c_ready_i, c_flush, c_done;
  logic [63:0] c_data; logic [7:0] c_strb;
  logic [31:0] c_data_o; logic [3:0] c_strb_o; logic [3:0] c_level;

  prim_byte_packer #(.InW(32), .OutW(64)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(a_valid), .data_i(a_data), .strb_i(a_strb),
    .ready_o(a_ready), .valid_o(a_valid_o), .data_o(a_data_o), .strb_o(a_strb_o),
    .ready_i(a_ready_i), .flush_i(a_flush), .flush_done_o(a_done), .level_o(a_level));

  prim_byte_packer #(.InW(32), .OutW(32)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid), .data_i(b_data), .strb_i(b_strb),
    .ready_o(b_ready), .valid_o(b_valid_o), .data_o(b_data_o), .strb_o(b_strb_o),
    .ready_i(b_ready_i), .flush_i(b_flush), .flush_done_o(b_done), .level_o(b_level));

  prim_byte_packer #(.InW(64), .OutW(32)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(c_valid), .data_i(c_data), .strb_i(c_strb),
    .ready_o(c_ready), .valid_o(c_valid_o), .data_o(c_data_o), .strb_o(c_strb_o),
    .ready_i(c_ready_i), .flush_i(c_flush), .flush_done_o(c_done), .level_o(c_level));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_valid = 0; a_ready_i = 0; a_flush = 0; a_data = '0; a_strb = '0;
    b_valid = 0; b_ready_i = 0; b_flush = 0; b_data = '0; b_strb = '0;
    c_valid = 0; c_ready_i = 0; c_flush = 0; c_data = '0; c_strb = '0;

    #2;
    check("rst_ready", a_ready, 1);
    check("rst_valid", a_valid_o, 0);
    check("rst_data", a_data_o, 0);
    check("rst_strb", a_strb_o, 0);
    check("rst_done", a_done, 0);
    check("rst_level", a_level, 0);
    check("rst_level_c", c_level, 0);

    @(posedge clk); #1;
    rst_n = 1;

    // pack 32 -> 64
    a_ready_i = 1; a_valid = 1; a_data = 32'h44332211; a_strb = 4'hF;
    step();
    check("pack_level1", a_level, 4);
    check("pack_valid1", a_valid_o, 0);
    a_data = 32'h88776655;
    step();
    check("pack_valid2", a_valid_o, 1);
    check("pack_data", a_data_o, 64'h8877665544332211);
    check("pack_strb", a_strb_o, 8'hFF);
    check("pack_level2", a_level, 8);
    a_valid = 0;
    step();
    check("pack_level3", a_level, 0);
    check("pack_valid3", a_valid_o, 0);

    // sparse strobes 32 -> 32, then backpressure from cnt=4
    b_valid = 1; b_data = 32'hDDCCBBAA; b_strb = 4'b1010;
    step();
    check("sparse_level1", b_level, 2);
    check("sparse_valid1", b_valid_o, 0);
    b_data = 32'h00FF00EE; b_strb = 4'b0101;
    step();
    check("sparse_valid2", b_valid_o, 1);
    check("sparse_data", b_data_o, 32'hFFEEDDBB);
    check("sparse_strb", b_strb_o, 4'hF);
    check("sparse_level2", b_level, 4);
    b_valid = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_data", b_data_o, 32'hFFEEDDBB);
      check("bp_valid", b_valid_o, 1);
    end
    check("bp_ready", b_ready, 1);
    b_ready_i = 1; b_valid = 1; b_data = 32'h44332211; b_strb = 4'hF;
    step();
    check("simul_level", b_level, 4);
    check("simul_data", b_data_o, 32'h44332211);
    b_valid = 0;
    step();
    check("simul_drain", b_level, 0);
    b_ready_i = 0;

    // unpack 64 -> 32
    c_ready_i = 1; c_valid = 1; c_data = 64'h0807060504030201; c_strb = 8'hFF;
    step();
    check("unpack_level1", c_level, 8);
    check("unpack_valid1", c_valid_o, 1);
    check("unpack_data1", c_data_o, 32'h04030201);
    check("unpack_ready1", c_ready, 0);
    c_valid = 0;
    step();
    check("unpack_level2", c_level, 4);
    check("unpack_data2", c_data_o, 32'h08070605);
    check("unpack_valid2", c_valid_o, 1);
    check("unpack_ready2", c_ready, 1);
    step();
    check("unpack_level3", c_level, 0);
    check("unpack_valid3", c_valid_o, 0);

    // flush remnant 32 -> 64
    a_valid = 1; a_data = 32'h00CCBBAA; a_strb = 4'h7;
    step();
    check("fl_level", a_level, 3);
    check("fl_valid0", a_valid_o, 0);
    check("fl_ready0", a_ready, 1);
    a_valid = 0; a_flush = 1;
    step();
    check("fl_valid", a_valid_o, 1);
    check("fl_data", a_data_o, 64'h0000000000CCBBAA);
    check("fl_strb", a_strb_o, 8'h07);
    check("fl_ready1", a_ready, 0);
    check("fl_done0", a_done, 0);
    a_flush = 0;
    step();
    check("fl_done1", a_done, 1);
    check("fl_level_done", a_level, 0);
    check("fl_ready2", a_ready, 0);
    check("fl_valid_done", a_valid_o, 0);
    step();
    check("fl_done2", a_done, 0);
    check("fl_ready3", a_ready, 1);

    // empty flush 32 -> 32
    b_flush = 1;
    step();
    check("ef_done0", b_done, 0);
    check("ef_ready0", b_ready, 0);
    check("ef_valid0", b_valid_o, 0);
    b_flush = 0;
    step();
    check("ef_done1", b_done, 1);
    step();
    check("ef_done2", b_done, 0);
    check("ef_ready2", b_ready, 1);

    // all-zero strobe, then a partial push and asynchronous reset
    b_valid = 1; b_data = 32'hFFFFFFFF; b_strb = 4'h0;
    step();
    check("zs_level", b_level, 0);
    check("zs_ready", b_ready, 1);
    b_data = 32'h0000BBAA; b_strb = 4'h3;
    step();
    b_valid = 0;
    check("part_level", b_level, 2);
    check("part_data", b_data_o, 32'h0000BBAA);
    check("part_strb", b_strb_o, 4'h3);
    check("part_valid", b_valid_o, 0);
    #2;
    rst_n = 0;
    #1;
    check("arst_level", b_level, 0);
    check("arst_valid", b_valid_o, 0);
    check("arst_ready", b_ready, 1);
    check("arst_data", b_data_o, 0);
    step();
    rst_n = 1;
    step();
    check("post_rst_level", b_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
